oversample_multichannel: RTL and testbench
==========================================

# oversample_multichannel

Parametrised multi-channel oversampling decimator for the XADC front end. It accumulates 4^k conversions per channel, with k selectable at run time. It then emits one rounded, (SAMPLE_W+k)-bit result per block, left-aligned to a fixed output width so downstream scaling is independent of k. It sits between the XADC sequencer (eoc + channel tag) and the FFT input buffer, and replaces the fixed single-channel 16x/256x oversamplers.

## Interface
- SAMPLE_W, 12, raw ADC sample width
- CHANNELS, 4, number of independent channels (1..16)
- MAX_K, 4, maximum log4 of the oversample ratio (ratio up to 4^MAX_K)
- Derived: CH_W = max(1, clog2(CHANNELS)); K_W = clog2(MAX_K+1); OUT_W = SAMPLE_W+MAX_K; ACC_W = SAMPLE_W+2*MAX_K
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- sample  in  SAMPLE_W  unsigned conversion result, valid when eoc=1
- eoc  in  1  end-of-conversion strobe; one sample per high cycle
- channel  in  CH_W  channel tag of sample, valid when eoc=1
- ratio_sel  in  K_W  requested k; values > MAX_K are clamped to MAX_K
- oversample  out  OUT_W  rounded result, left-aligned
- out_channel  out  CH_W  channel that produced oversample
- done  out  1  one-cycle strobe: oversample/out_channel valid

## Operation
- Per-channel state: acc[c] (ACC_W bits), cnt[c] (2*MAX_K bits); register arrays, not BRAM.
- The active ratio is held in register k_reg, loaded from clamp(ratio_sel).
- eoc=1 with channel >= CHANNELS: sample ignored, no state change.
- eoc=1 with a valid channel c, and cnt[c] != 4^k_reg - 1:
  - acc[c] <= acc[c] + sample
  - cnt[c] <= cnt[c] + 1
- eoc=1 with a valid channel c, and cnt[c] == 4^k_reg - 1 (block complete):
  - total = acc[c] + sample
  - oversample <= ((total + R) >> k_reg) << (MAX_K - k_reg), where R = 2^(k_reg-1) for k_reg>0, else 0 (round half up)
  - out_channel <= c; done <= 1
  - acc[c] <= 0; cnt[c] <= 0
- No saturation is needed: the maximum rounded result is (2^SAMPLE_W - 1)*2^k, which fits in SAMPLE_W+k bits. All intermediate sums are computed at ACC_W+1 bits.
- k_reg = 0: pass-through. Every valid eoc yields done, with oversample = sample << MAX_K.
- Ratio change: when clamp(ratio_sel) != k_reg on a clock edge:
  - k_reg is updated
  - every acc and cnt is cleared
  - any eoc on that cycle is discarded and done is not asserted
  - partial blocks are dropped, never emitted
- Channels are fully independent. Interleaving order is arbitrary, and consecutive eocs on the same channel are legal.
- No backpressure: the consumer must accept each done strobe.

## Timing
- Reset (synchronous, takes priority over everything):
  - done=0, oversample=0, out_channel=0
  - all acc=0, all cnt=0
  - k_reg <= clamp(ratio_sel)
- The first eoc is accepted on the cycle after reset deasserts.
- Latency: eoc on the edge at cycle n that completes a block gives done=1 during cycle n+1, with oversample and out_channel valid in that same cycle.
- oversample and out_channel hold their values until the next done. done is high for exactly one cycle per completed block.
- Throughput: one eoc per clock sustained, with any channel sequence.
- A block completing and a ratio change on the same edge: the ratio change wins and no done is produced.
- Counter wrap: cnt never exceeds 4^k_reg - 1. It returns to 0 exactly at block completion.

## Test plan
1. CHANNELS=4, MAX_K=4, k=2; 16 eocs on ch0 of 0xFFF -> the cycle after the 16th eoc: done=1, out_channel=0, oversample=0xFFF0. No done is seen earlier.
2. k=1; alternate ch0=100 and ch1=200, 4 samples each -> exactly two dones, in completion order:
   - ch0: oversample=1600 ((400+1)>>1=200, <<3)
   - ch1: oversample=3200
3. k=0; eoc ch2, sample=0x123 -> next cycle done=1, out_channel=2, oversample=0x1230. Back-to-back eocs give a done every cycle.
4. Rounding at k=4:
   - 255 samples of 0 plus one 8 -> oversample=1
   - 255 zeros plus one 7 -> oversample=0
5. k=2; 10 eocs of 50 on ch0, then ratio_sel=1 concurrent with an eoc, then 4 eocs of 50 -> only one done, oversample=800. The concurrent eoc and the old partial are discarded.
6. Mixed boundary cases:
   - reset mid-block (7 of 16 samples) -> all outputs 0. The next full block of 16×10 gives oversample=160.
   - ratio_sel=7 -> behaves as k=4.
   - CHANNELS=3, eocs tagged channel 3 -> never produce done or change state.

Source files
------------

// File: rtl/oversample_multichannel.sv
// oversample_multichannel
// Multi-channel oversampling decimator. Each channel accumulates 4^k conversions.
// When a block completes, the rounded (SAMPLE_W+k)-bit mean-times-2^k is emitted.
// The result is left-aligned to SAMPLE_W+MAX_K bits, so downstream scaling
// does not depend on k. Changing k drops every partial block.
module oversample_multichannel #(
  parameter  int SAMPLE_W = 12,
  parameter  int CHANNELS = 4,
  parameter  int MAX_K    = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int K_W      = $clog2(MAX_K + 1),
  localparam int OUT_W    = SAMPLE_W + MAX_K
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                eoc,
  input  logic [CH_W-1:0]     channel,
  input  logic [K_W-1:0]      ratio_sel,
  output logic [OUT_W-1:0]    oversample,
  output logic [CH_W-1:0]     out_channel,
  output logic                done
);

  localparam int ACC_W = SAMPLE_W + 2 * MAX_K;
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = 2 * MAX_K;

  logic [ACC_W-1:0] acc_q [CHANNELS];
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [K_W-1:0]   k_q;
  logic [OUT_W-1:0] oversample_q;
  logic [CH_W-1:0]  outChannel_q;
  logic             done_q;

  logic [K_W-1:0]   kClamp;
  logic             ratioChange;
  logic             chValid;
  logic [CH_W-1:0]  chIdx;
  logic [CNT_W-1:0] cntTarget;
  logic             blockDone;
  logic [SUM_W-1:0] total_d;
  logic [SUM_W-1:0] roundBias;
  logic [SUM_W-1:0] rounded;
  logic [OUT_W-1:0] oversample_d;

  // A full power-of-two channel field can never carry an out-of-range tag
  if (CHANNELS == (1 << CH_W)) begin : gAllValid
    assign chValid = 1'b1;
  end else begin : gPartValid
    assign chValid = (channel < CH_W'(CHANNELS));
  end

  // Decode the requested ratio, the block-end count and the rounded, left-aligned result
  always_comb begin
    kClamp       = (ratio_sel > K_W'(MAX_K)) ? K_W'(MAX_K) : ratio_sel;
    ratioChange  = (kClamp != k_q);
    chIdx        = chValid ? channel : '0;
    cntTarget    = {CNT_W{1'b1}} >> (2 * (MAX_K - int'(k_q)));
    blockDone    = eoc && chValid && (cnt_q[chIdx] == cntTarget);
    total_d      = SUM_W'(acc_q[chIdx]) + SUM_W'(sample);
    roundBias    = (k_q == '0) ? '0 : (SUM_W'(1) << (k_q - K_W'(1)));
    rounded      = (total_d + roundBias) >> k_q;
    oversample_d = OUT_W'(rounded << (MAX_K - int'(k_q)));
  end

  // Per-channel accumulation, block emission, and ratio-change flush (flush beats completion)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      k_q          <= kClamp;
      done_q       <= 1'b0;
      oversample_q <= '0;
      outChannel_q <= '0;
    end else if (ratioChange) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      k_q    <= kClamp;
      done_q <= 1'b0;
    end else begin
      done_q <= blockDone;
      if (blockDone) begin
        oversample_q  <= oversample_d;
        outChannel_q  <= chIdx;
        acc_q[chIdx]  <= '0;
        cnt_q[chIdx]  <= '0;
      end else if (eoc && chValid) begin
        acc_q[chIdx]  <= acc_q[chIdx] + ACC_W'(sample);
        cnt_q[chIdx]  <= cnt_q[chIdx] + CNT_W'(1);
      end
    end
  end

  assign oversample  = oversample_q;
  assign out_channel = outChannel_q;
  assign done        = done_q;

endmodule

// File: tb/tb_oversample_multichannel.sv
// tb_oversample_multichannel
// Directed vectors for the multi-channel oversampler.
// Expected results are hand-computed and queued when the completing eoc is driven.
// A separate monitor pops and compares on every done strobe.
module tb_oversample_multichannel;

  localparam int SAMPLE_W = 12;
  localparam int MAX_K    = 4;
  localparam int OUT_W    = SAMPLE_W + MAX_K;

  typedef struct {
    int ch;
    int val;
    int cyc;
  } expT;

  logic                clk;
  logic                reset;
  logic [SAMPLE_W-1:0] sample;
  logic                eoc;
  logic [1:0]          channel;
  logic [2:0]          ratio_sel;
  logic [OUT_W-1:0]    oversample;
  logic [1:0]          out_channel;
  logic                done;

  logic [SAMPLE_W-1:0] sample3;
  logic                eoc3;
  logic [1:0]          channel3;
  logic [2:0]          ratio_sel3;
  logic [OUT_W-1:0]    oversample3;
  logic [1:0]          out_channel3;
  logic                done3;

  expT sbQ[$];
  int  nChecks = 0;
  int  nFail   = 0;
  int  cyc     = 0;
  int  done3Count = 0;
  int  last3Val   = -1;
  int  last3Ch    = -1;

  oversample_multichannel #(.SAMPLE_W(SAMPLE_W), .CHANNELS(4), .MAX_K(MAX_K)) dut (
    .clk(clk), .reset(reset), .sample(sample), .eoc(eoc), .channel(channel),
    .ratio_sel(ratio_sel), .oversample(oversample), .out_channel(out_channel), .done(done)
  );

  oversample_multichannel #(.SAMPLE_W(SAMPLE_W), .CHANNELS(3), .MAX_K(MAX_K)) dut3 (
    .clk(clk), .reset(reset), .sample(sample3), .eoc(eoc3), .channel(channel3),
    .ratio_sel(ratio_sel3), .oversample(oversample3), .out_channel(out_channel3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to pin the one-cycle done latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit e, input int ch, input int smp, input int rsel,
                               input int expVal, input int expCh);
    @(negedge clk);
    eoc       = e;
    channel   = 2'(ch);
    sample    = SAMPLE_W'(smp);
    ratio_sel = 3'(rsel);
    if (expVal >= 0) sbQ.push_back('{ch: expCh, val: expVal, cyc: cyc + 1});
  endtask

  task automatic runBlock(input int ch, input int smp, input int n, input int rsel, input int expVal);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, ch, smp, rsel, (i == n - 1) ? expVal : -1, ch);
  endtask

  task automatic setRatio(input int rsel);
    applyStimulus(1'b0, 0, 0, rsel, -1, 0);
  endtask

  task automatic drive3(input int ch, input int smp);
    @(negedge clk);
    eoc3     = 1'b1;
    channel3 = 2'(ch);
    sample3  = SAMPLE_W'(smp);
  endtask

  // Scoreboard monitor: every done must match the head of the queue, on time
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", int'(oversample), -1);
      end else begin
        expT e;
        e = sbQ.pop_front();
        checkOutput("out_channel", int'(out_channel), e.ch);
        checkOutput("oversample", int'(oversample), e.val);
        checkOutput("done_cycle", cyc, e.cyc);
      end
    end else if (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      checkOutput("missing_done_cycle", cyc, -1);
      void'(sbQ.pop_front());
    end
  end

  // Records every strobe from the three-channel instance
  always @(negedge clk) begin
    if (!reset && done3) begin
      done3Count <= done3Count + 1;
      last3Val   <= int'(oversample3);
      last3Ch    <= int'(out_channel3);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b1;
    eoc        = 1'b0;
    channel    = '0;
    sample     = '0;
    ratio_sel  = 3'd2;
    eoc3       = 1'b0;
    channel3   = '0;
    sample3    = '0;
    ratio_sel3 = 3'd1;
    repeat (3) @(negedge clk);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_oversample", int'(oversample), 0);
    checkOutput("reset_out_channel", int'(out_channel), 0);
    reset = 1'b0;

    // k=2: sixteen full-scale samples on ch0
    runBlock(0, 'hFFF, 16, 2, 'hFFF0);
    setRatio(2);

    // k=1: interleaved ch0/ch1, completion order ch0 then ch1
    setRatio(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 0, 100, 1, (i == 3) ? 1600 : -1, 0);
      applyStimulus(1'b1, 1, 200, 1, (i == 3) ? 3200 : -1, 1);
    end

    // k=0: pass-through, back-to-back dones
    setRatio(0);
    applyStimulus(1'b1, 2, 'h123, 0, 'h1230, 2);
    applyStimulus(1'b1, 0, 5, 0, 80, 0);
    applyStimulus(1'b1, 3, 'hFFF, 0, 'hFFF0, 3);
    applyStimulus(1'b1, 1, 1, 0, 16, 1);

    // k=4: round half up at the boundary
    setRatio(4);
    runBlock(0, 0, 255, 4, -1);
    applyStimulus(1'b1, 0, 8, 4, 1, 0);
    runBlock(1, 0, 255, 4, -1);
    applyStimulus(1'b1, 1, 7, 4, 0, 1);

    // ratio_sel=7 clamps to 4: a partial block survives the switch
    runBlock(3, 100, 3, 4, -1);
    setRatio(7);
    runBlock(3, 100, 253, 7, 1600);
    runBlock(2, 1, 256, 7, 16);

    // Ratio change concurrent with an eoc drops the old partial and that eoc
    setRatio(2);
    runBlock(0, 50, 10, 2, -1);
    applyStimulus(1'b1, 0, 50, 1, -1, 0);
    runBlock(0, 50, 4, 1, 800);

    // Completion edge coinciding with a ratio change emits nothing
    runBlock(1, 10, 3, 1, -1);
    applyStimulus(1'b1, 1, 10, 2, -1, 1);
    runBlock(1, 20, 16, 2, 320);

    // Reset in the middle of a block
    runBlock(0, 10, 7, 2, -1);
    @(negedge clk);
    eoc   = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_oversample", int'(oversample), 0);
    checkOutput("midreset_out_channel", int'(out_channel), 0);
    reset = 1'b0;
    runBlock(0, 10, 16, 2, 160);
    setRatio(2);

    // Three-channel instance at k=1: channel 3 tags must be ignored
    drive3(0, 100);
    drive3(0, 100);
    for (int i = 0; i < 4; i++) drive3(3, 'hFFF);
    @(negedge clk);
    eoc3 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("ch3_no_done", done3Count, 0);
    drive3(0, 100);
    drive3(0, 100);
    @(negedge clk);
    eoc3 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ch3_done_count", done3Count, 1);
    checkOutput("ch3_oversample", last3Val, 1600);
    checkOutput("ch3_out_channel", last3Ch, 0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
